// File: rtl/regfile_wb_scheduler_if.sv
// Write-back bus between the two producers, decode and the register-file write port.
// The master side drives the requests; the scheduler sits on the slave side.
interface regfile_wb_scheduler_if;
    logic        s0_valid;
    logic [4:0]  s0_rd;
    logic [31:0] s0_data;
    logic        s0_ready;

    logic        s1_valid;
    logic [4:0]  s1_rd;
    logic [31:0] s1_data;
    logic        s1_ready;

    logic        issue_valid;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic [4:0]  issue_rd;
    logic        issue_ready;

    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;

    modport master (
        output s0_valid, s0_rd, s0_data,
        input  s0_ready,
        output s1_valid, s1_rd, s1_data,
        input  s1_ready,
        output issue_valid, issue_rs1, issue_rs2, issue_rd,
        input  issue_ready,
        input  rf_we, rf_rd, rf_data
    );

    modport slave (
        input  s0_valid, s0_rd, s0_data,
        output s0_ready,
        input  s1_valid, s1_rd, s1_data,
        output s1_ready,
        input  issue_valid, issue_rs1, issue_rs2, issue_rd,
        output issue_ready,
        output rf_we, rf_rd, rf_data
    );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Write-back arbiter (ALU vs load) with registered register-file write port,
// pending-write scoreboard for RAW/WAW issue gating and a contention counter.
module regfile_wb_scheduler #(
    parameter bit RESET_PRIO = 1'b0,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_scheduler_if.slave bus,
    output logic [31:0]          pending,
    output logic [CNT_W-1:0]     conflict_cnt
);
    typedef enum logic {
        SRC_S0 = 1'b0,
        SRC_S1 = 1'b1
    } src_e;

    src_e        prio;
    logic        grant0;
    logic        grant1;
    logic        transfer;
    logic [4:0]  sel_rd;
    logic [31:0] sel_data;

    logic        rf_we_q;
    logic [4:0]  rf_rd_q;
    logic [31:0] rf_data_q;

    logic [31:0]      pending_q;
    logic [31:0]      set_mask;
    logic [31:0]      clr_mask;
    logic [31:0]      pending_next;
    logic             issue_ok;
    logic             issue_fire;
    logic [CNT_W-1:0] cnt_q;

    // Single grant per cycle; prio only breaks ties when both producers request.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (bus.s0_valid && bus.s1_valid) begin
            grant0 = (prio == SRC_S0);
            grant1 = (prio == SRC_S1);
        end else begin
            grant0 = bus.s0_valid;
            grant1 = bus.s1_valid;
        end
    end

    assign transfer     = grant0 | grant1;
    assign sel_rd       = grant1 ? bus.s1_rd   : bus.s0_rd;
    assign sel_data     = grant1 ? bus.s1_data : bus.s0_data;
    assign bus.s0_ready = grant0;
    assign bus.s1_ready = grant1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio <= RESET_PRIO ? SRC_S1 : SRC_S0;
        end else if (grant0) begin
            prio <= SRC_S1;
        end else if (grant1) begin
            prio <= SRC_S0;
        end
    end

    // A transfer to x0 still updates the address/data registers but never writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_q   <= 1'b0;
            rf_rd_q   <= 5'd0;
            rf_data_q <= 32'd0;
        end else if (transfer) begin
            rf_we_q   <= (sel_rd != 5'd0);
            rf_rd_q   <= sel_rd;
            rf_data_q <= sel_data;
        end else begin
            rf_we_q   <= 1'b0;
        end
    end

    assign bus.rf_we   = rf_we_q;
    assign bus.rf_rd   = rf_rd_q;
    assign bus.rf_data = rf_data_q;

    assign issue_ok = !pending_q[bus.issue_rs1] &&
                      !pending_q[bus.issue_rs2] &&
                      !pending_q[bus.issue_rd];
    assign issue_fire      = bus.issue_valid && issue_ok;
    assign bus.issue_ready = issue_ok;

    // Clear follows the register-file write edge; a set on the same bit wins.
    always_comb begin
        set_mask = 32'd0;
        clr_mask = 32'd0;
        if (issue_fire && (bus.issue_rd != 5'd0)) begin
            set_mask[bus.issue_rd] = 1'b1;
        end
        if (rf_we_q) begin
            clr_mask[rf_rd_q] = 1'b1;
        end
        pending_next    = (pending_q & ~clr_mask) | set_mask;
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= 32'd0;
        end else begin
            pending_q <= pending_next;
        end
    end

    assign pending = pending_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (bus.s0_valid && bus.s1_valid && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign conflict_cnt = cnt_q;
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler; expected writes are queued at handshake
// time and a negedge monitor compares them against the register-file write port.
module tb_regfile_wb_scheduler;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_wb_scheduler_if bus();
    logic [31:0]      pending;
    logic [CNT_W-1:0] conflict_cnt;

    regfile_wb_scheduler #(
        .RESET_PRIO(1'b0),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .pending     (pending),
        .conflict_cnt(conflict_cnt)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    wb_t exp_q[$];
    wb_t mon_e;
    int  n_checks = 0;
    int  n_pass   = 0;

    bit          m_prio;
    logic [31:0] m_pend;
    int          m_cnt;
    bit          m_wb_valid;
    logic [4:0]  m_wb_rd;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic model_reset();
        m_prio     = 1'b0;
        m_pend     = 32'd0;
        m_cnt      = 0;
        m_wb_valid = 1'b0;
        m_wb_rd    = 5'd0;
        exp_q.delete();
    endtask

    task automatic drive_idle();
        bus.s0_valid = 1'b0; bus.s0_rd = 5'd0; bus.s0_data = 32'd0;
        bus.s1_valid = 1'b0; bus.s1_rd = 5'd0; bus.s1_data = 32'd0;
        bus.issue_valid = 1'b0; bus.issue_rs1 = 5'd0; bus.issue_rs2 = 5'd0; bus.issue_rd = 5'd0;
    endtask

    // Each written register leaves exactly one queued entry, seen one cycle after its handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check_output("rf_we", 32'(bus.rf_we), 32'd1);
                check_output("rf_rd", 32'(bus.rf_rd), 32'(mon_e.rd));
                check_output("rf_data", bus.rf_data, mon_e.data);
            end else begin
                check_output("rf_we_idle", 32'(bus.rf_we), 32'd0);
            end
        end
    end

    task automatic apply_stimulus(
        input bit v0, input logic [4:0] rd0, input logic [31:0] d0,
        input bit v1, input logic [4:0] rd1, input logic [31:0] d1,
        input bit iv, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] ird);
        bit g0, g1, er;
        logic [31:0] clr, set;
        @(negedge clk);
        bus.s0_valid = v0; bus.s0_rd = rd0; bus.s0_data = d0;
        bus.s1_valid = v1; bus.s1_rd = rd1; bus.s1_data = d1;
        bus.issue_valid = iv; bus.issue_rs1 = rs1; bus.issue_rs2 = rs2; bus.issue_rd = ird;
        #1;
        g0 = v0 && (!v1 || !m_prio);
        g1 = v1 && (!v0 || m_prio);
        er = !m_pend[rs1] && !m_pend[rs2] && !m_pend[ird];
        check_output("s0_ready", 32'(bus.s0_ready), 32'(g0));
        check_output("s1_ready", 32'(bus.s1_ready), 32'(g1));
        check_output("issue_ready", 32'(bus.issue_ready), 32'(er));
        check_output("pending", pending, m_pend);
        check_output("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
        if (g0 && rd0 != 5'd0) exp_q.push_back('{rd: rd0, data: d0});
        if (g1 && rd1 != 5'd0) exp_q.push_back('{rd: rd1, data: d1});
        clr = 32'd0;
        set = 32'd0;
        if (m_wb_valid) clr[m_wb_rd] = 1'b1;
        if (iv && er && ird != 5'd0) set[ird] = 1'b1;
        m_pend     = (m_pend & ~clr) | set;
        m_wb_valid = (g0 && rd0 != 5'd0) || (g1 && rd1 != 5'd0);
        m_wb_rd    = g1 ? rd1 : rd0;
        if (g0) m_prio = 1'b1;
        else if (g1) m_prio = 1'b0;
        if (v0 && v1 && m_cnt < CNT_MAX) m_cnt++;
    endtask

    task automatic idle_cycle();
        apply_stimulus(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic issue_only(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] ird);
        apply_stimulus(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, rs1, rs2, ird);
    endtask

    task automatic s0_only(input logic [4:0] rd, input logic [31:0] d);
        apply_stimulus(1, rd, d, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 5'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        drive_idle();
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_output("reset_rf_we", 32'(bus.rf_we), 32'd0);
        check_output("reset_rf_rd", 32'(bus.rf_rd), 32'd0);
        check_output("reset_rf_data", bus.rf_data, 32'd0);
        check_output("reset_pending", pending, 32'd0);
        check_output("reset_cnt", 32'(conflict_cnt), 32'd0);
        check_output("reset_issue_ready", 32'(bus.issue_ready), 32'd1);
        rst = 1'b0;

        // Simultaneous requests after reset: S0 first, held S1 next cycle
        apply_stimulus(1, 5'd5, 32'h11, 1, 5'd6, 32'h22, 0, 5'd0, 5'd0, 5'd0);
        apply_stimulus(0, 5'd0, 32'd0,  1, 5'd6, 32'h22, 0, 5'd0, 5'd0, 5'd0);
        idle_cycle();
        check_output("cnt_after_first_pair", 32'(conflict_cnt), 32'd1);

        // Continuous dual requests; losers hold data until granted
        for (int i = 0; i < 26; i++) begin
            apply_stimulus(1, 5'd11, 32'h1000 + 32'((i + 1) / 2),
                           1, 5'd12, 32'h2000 + 32'(i / 2), 0, 5'd0, 5'd0, 5'd0);
            if (i == 5) check_output("cnt_after_alternation", 32'(conflict_cnt), 32'd6);
        end
        idle_cycle();
        check_output("cnt_saturated", 32'(conflict_cnt), 32'(CNT_MAX));

        // RAW and WAW gating on x7
        issue_only(5'd0, 5'd0, 5'd7);
        issue_only(5'd7, 5'd0, 5'd0);
        check_output("pending_x7", pending, 32'h0000_0080);
        issue_only(5'd0, 5'd0, 5'd7);
        apply_stimulus(1, 5'd7, 32'h77, 0, 5'd0, 32'd0, 1, 5'd7, 5'd0, 5'd0);
        issue_only(5'd7, 5'd0, 5'd0);
        issue_only(5'd7, 5'd0, 5'd0);
        check_output("pending_x7_cleared", pending, 32'd0);

        // Write to x0 is consumed silently; issue to x0 never marks pending
        s0_only(5'd0, 32'hDEAD);
        issue_only(5'd0, 5'd0, 5'd0);
        idle_cycle();
        check_output("pending_x0", pending, 32'd0);

        // Set and clear of x9 on the same edge: set wins
        s0_only(5'd9, 32'h99);
        issue_only(5'd0, 5'd0, 5'd9);
        idle_cycle();
        check_output("pending_x9_set_wins", pending, 32'h0000_0200);
        s0_only(5'd9, 32'h999);
        idle_cycle();
        idle_cycle();

        // Reset while x7/x10 pending and a write sits on the port
        issue_only(5'd0, 5'd0, 5'd7);
        issue_only(5'd0, 5'd0, 5'd10);
        s0_only(5'd7, 32'h7777);
        @(negedge clk);
        #3;
        check_output("pre_reset_pending", pending, 32'h0000_0480);
        check_output("pre_reset_rf_we", 32'(bus.rf_we), 32'd1);
        rst = 1'b1;
        drive_idle();
        model_reset();
        #1;
        check_output("mid_reset_rf_we", 32'(bus.rf_we), 32'd0);
        check_output("mid_reset_pending", pending, 32'd0);
        check_output("mid_reset_cnt", 32'(conflict_cnt), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        issue_only(5'd7, 5'd10, 5'd7);
        issue_only(5'd10, 5'd0, 5'd3);
        idle_cycle();
        idle_cycle();
        check_output("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
